apb_master_bridge: RTL
======================

// Module: apb_master_bridge
// PURPOSE
// - APB initiator that turns single-beat command requests from a local bus into APB transfers (SETUP -> ACCESS).
// - Sits between a simple command/response port and APB responders such as the CRC peripheral wrappers.
// - Completes one transfer at a time and returns read data plus an error flag per command.
// PARAMETERS
// - ADDR_W       32     width of p_adr_o and cmd_addr_i
// - DATA_W       32     width of the APB data buses and of the command/response data
// - TIMEOUT_CYC  16     max ACCESS cycles waited for p_ready_i (used only with APB_TIMEOUT_EN); must be >= 1
// PORTS
// - p_clk_i      in   1       APB clock, all logic on the rising edge
// - p_rst_n_i    in   1       reset, asynchronous, active-low
// - cmd_valid_i  in   1       command request
// - cmd_ready_o  out  1       command accepted when cmd_valid_i && cmd_ready_o
// - cmd_we_i     in   1       1 = write, 0 = read
// - cmd_addr_i   in   ADDR_W  target register address
// - cmd_wdata_i  in   DATA_W  write data (ignored on reads)
// - rsp_valid_o  out  1       response available
// - rsp_ready_i  in   1       response consumed when rsp_valid_o && rsp_ready_i
// - rsp_rdata_o  out  DATA_W  read data (0 for writes and on error)
// - rsp_err_o    out  1       transfer aborted by timeout
// - p_adr_o      out  ADDR_W  APB address
// - p_dat_o      out  DATA_W  APB write data
// - p_dat_i      in   DATA_W  APB read data
// - p_sel_o      out  1       APB select
// - p_enable_o   out  1       APB enable
// - p_we_o       out  1       APB write strobe
// - p_ready_i    in   1       APB responder ready
// BEHAVIOUR
// - Reset: all outputs 0 except cmd_ready_o = 1. State goes to IDLE. Any transfer in flight is dropped with no response.
// - FSM states: IDLE, SETUP, ACCESS.
//   - IDLE -> SETUP on command accept.
//   - SETUP -> ACCESS unconditionally after one cycle.
//   - ACCESS -> IDLE when p_ready_i = 1, or on timeout.
// - cmd_ready_o = (state == IDLE) && !rsp_valid_o. No new command is accepted while a response is pending.
// - Accept: cmd_we/addr/wdata are registered. They drive p_we_o, p_adr_o and p_dat_o for both SETUP and ACCESS, and stay stable for the whole transfer.
// - SETUP: p_sel_o = 1, p_enable_o = 0. ACCESS: p_sel_o = 1, p_enable_o = 1.
// - ACCESS with p_ready_i = 1:
//   - on a read, p_dat_i is captured into rsp_rdata_o;
//   - rsp_valid_o = 1 and rsp_err_o = 0 next cycle;
//   - p_sel_o, p_enable_o, p_we_o, p_adr_o and p_dat_o return to 0 in that same next cycle.
// - Latency: command accepted at edge N, SETUP in N+1, ACCESS in N+2. Zero-wait responder gives rsp_valid_o in N+3. Each wait state adds 1 cycle.
// - rsp_valid_o, rsp_rdata_o and rsp_err_o are held until rsp_ready_i. cmd_ready_o rises the cycle after the response is consumed.
// - p_ready_i outside ACCESS is ignored.
// - cmd_valid_i while cmd_ready_o = 0 is ignored; the requester must hold it.
// - Reset asserted mid-transfer drops p_sel_o and p_enable_o asynchronously.
// CONFIGURATION
// - Macro APB_TIMEOUT_EN:
//   - defined: a wait counter starts at 0 on entry to ACCESS and increments each ACCESS cycle with p_ready_i = 0.
//   - On the TIMEOUT_CYC-th such cycle the FSM goes to IDLE with rsp_valid_o = 1, rsp_err_o = 1, rsp_rdata_o = 0.
//   - p_ready_i in the same cycle as the timeout wins: normal completion.
// - Not defined: no counter, ACCESS waits indefinitely, rsp_err_o is tied to 0.
// STRUCTURE
// - Shared package apb_pkg:
//   - apb_state_t enum {IDLE, SETUP, ACCESS};
//   - default widths APB_ADDR_W and APB_DATA_W;
//   - typedef apb_cmd_t struct {we, addr, wdata}.
// - Peripheral register addresses stay in crc_pkg; the bench imports both packages.
// - One sub-module: apb_wait_timer. It holds the ACCESS wait counter and the timeout compare, and is instantiated only under APB_TIMEOUT_EN.
// TESTING
// - Write 0xAA to the CRC8 write address with a zero-wait responder:
//   - SETUP then ACCESS with p_dat_o = 0xAA and p_we_o = 1;
//   - rsp_valid_o 3 cycles after accept, rsp_err_o = 0, rsp_rdata_o = 0.
// - Read with 2 wait states, p_dat_i = 0x0000_005C:
//   - p_enable_o high for 3 cycles, addr stable throughout;
//   - rsp_rdata_o = 0x5C, rsp_valid_o 5 cycles after accept.
// - Back-to-back writes 0xAA then 0x33 with rsp_ready_i held high:
//   - the second accept is exactly 1 cycle after the first response;
//   - p_sel_o is low for at least 1 cycle between transfers.
// - Response back-pressure: rsp_ready_i = 0 for 4 cycles.
//   - rsp_valid_o and data stay stable, cmd_ready_o stays 0, no APB activity.
// - Timeout with APB_TIMEOUT_EN and TIMEOUT_CYC = 16, p_ready_i held low:
//   - abort after 16 ACCESS cycles, rsp_err_o = 1, rsp_rdata_o = 0;
//   - the next command completes normally.
// - Reset pulse during ACCESS:
//   - p_sel_o and p_enable_o go to 0 immediately, no rsp_valid_o;
//   - cmd_ready_o = 1 after release.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB initiator types: FSM states, default bus widths and the latched command.
// No logic; imported by the bridge, its wait timer and the bench.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    typedef struct packed {
        logic                  we;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

endpackage

// File: rtl/crc_pkg.sv
// Register map of the CRC peripheral wrappers reachable over APB.
// Addresses only; no logic.
package crc_pkg;

    localparam logic [31:0] CRC8_WR_ADDR = 32'h4000_0010;
    localparam logic [31:0] CRC8_RD_ADDR = 32'h4000_0014;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles without p_ready and flags the TIMEOUT_CYC-th one (combinational flag, 0 added latency).
// Only built into the bridge when APB_TIMEOUT_EN is defined; no backpressure of its own.
module apb_wait_timer #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Fires during the wait cycle itself, so the bridge can leave ACCESS at that edge.
    assign expired_o = inc_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// APB initiator: one accepted command -> SETUP/ACCESS -> held response; zero-wait latency is accept + 3 cycles.
// A pending response stalls on rsp_ready_i and blocks new commands; APB_TIMEOUT_EN adds an ACCESS wait timeout.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              p_clk_i,
    input  logic              p_rst_n_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic [ADDR_W-1:0] p_adr_o,
    output logic [DATA_W-1:0] p_dat_o,
    input  logic [DATA_W-1:0] p_dat_i,
    output logic              p_sel_o,
    output logic              p_enable_o,
    output logic              p_we_o,
    input  logic              p_ready_i
);

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout_cfg
        $error("apb_master_bridge: TIMEOUT_CYC must be >= 1");
    end

    apb_state_t        state_q, state_d;
    apb_cmd_t          cmd_q, cmd_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              accept;
    logic              busy;
    logic              timeout;

`ifdef APB_TIMEOUT_EN
    apb_wait_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wait_timer (
        .clk_i     (p_clk_i),
        .rst_n_i   (p_rst_n_i),
        .clr_i     (state_q == SETUP),
        .inc_i     ((state_q == ACCESS) && !p_ready_i),
        .expired_o (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    assign cmd_ready_o = (state_q == IDLE) && !rsp_valid_q;
    assign accept      = cmd_valid_i && cmd_ready_o;

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        if (rsp_valid_q && rsp_ready_i) begin
            rsp_valid_d = 1'b0;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = SETUP;
                    cmd_d.we    = cmd_we_i;
                    cmd_d.addr  = APB_ADDR_W'(cmd_addr_i);
                    cmd_d.wdata = APB_DATA_W'(cmd_wdata_i);
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                // A ready responder beats a timeout landing in the same cycle.
                if (p_ready_i) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = cmd_q.we ? '0 : p_dat_i;
                    rsp_err_d   = 1'b0;
                end else if (timeout) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge p_clk_i or negedge p_rst_n_i) begin
        if (!p_rst_n_i) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Bus outputs decode from the state register so an async reset drops them immediately.
    assign busy        = (state_q != IDLE);
    assign p_sel_o     = busy;
    assign p_enable_o  = (state_q == ACCESS);
    assign p_we_o      = busy && cmd_q.we;
    assign p_adr_o     = busy ? ADDR_W'(cmd_q.addr)  : '0;
    assign p_dat_o     = busy ? DATA_W'(cmd_q.wdata) : '0;

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule
